// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states and the request legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        ERR
    } state_e;

    // Unsigned widths exist only for loads; halfwords need even and words need 4-byte alignment.
    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response handshake plus memory port b signals of the load/store unit.
interface lsu_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: load extract with sign/zero extension, and store byte/half merge.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);
    logic [4:0]        sh;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;

    always_comb begin
        sh        = {off, 3'b000};
        lane      = rdata >> sh;
        load_data = rdata;
        mask      = '1;
        ins       = wdata;
        case (funct3)
            F3_B:    load_data = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            F3_BU:   load_data = {{(DATA_W-8){1'b0}}, lane[7:0]};
            F3_H:    load_data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            F3_HU:   load_data = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: load_data = rdata;
        endcase
        // Store side: only the addressed lane of the old word is replaced.
        case (funct3)
            F3_B: begin
                mask = DATA_W'(8'hFF) << sh;
                ins  = DATA_W'(wdata[7:0]) << sh;
            end
            F3_H: begin
                mask = DATA_W'(16'hFFFF) << sh;
                ins  = DATA_W'(wdata[15:0]) << sh;
            end
            default: begin
                mask = '1;
                ins  = wdata;
            end
        endcase
        merged = (rdata & ~mask) | (ins & mask);
    end
endmodule

// File: rtl/lsu_mem_port.sv
// RV32 load/store unit on memory port b: load RD_LAT+1, SW/error 1, SB/SH RD_LAT+2 edges to resp_valid.
// Backpressure: req_ready only in IDLE, so one request is in flight at a time.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_port_if.slave  bus
);
    localparam int               CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(RD_LAT);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;
    logic              unused_addr_hi;

    lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .funct3    (f3_q),
        .off       (off_q),
        .rdata     (bus.mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q       <= bus.req_we;
                        f3_q       <= bus.req_funct3;
                        off_q      <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata;
                        mem_addr_q <= bus.req_addr[ADDR_W+1:2];
                        cnt        <= '0;
                        if (!req_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                            state <= ERR;
                        end else if (bus.req_we && bus.req_funct3 == F3_W) begin
                            mem_wdata_q <= bus.req_wdata;
                            state       <= WRITE;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        if (we_q) begin
                            mem_wdata_q <= merged;
                            state       <= WRITE;
                        end else begin
                            resp_rdata_q <= load_data;
                            resp_valid_q <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state        <= IDLE;
                end
                ERR: begin
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state so a reset drops the write enable without waiting for an edge.
    assign bus.mem_we     = (state == WRITE);
    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
endmodule
